i2c_slave: RTL



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 61 ++++++
 rtl/i2c_slave.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave: FSM state encoding, R/W bit
// values, default address and byte width.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_DATA  = 4'd3,
    WR_ACK   = 4'd4,
    RD_DATA  = 4'd5,
    RD_ACK   = 4'd6,
    IGNORE   = 4'd7
  } i2c_state_t;

  localparam logic       I2C_WRITE        = 1'b0;
  localparam logic       I2C_READ         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h55;
  localparam int         BITS_PER_BYTE    = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one I2C line into clk, optionally glitch-filters it
// (I2C_SLAVE_GLITCH_FILTER_EN), and flags its rising/falling edges.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  , parameter int FILTER_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   clean;
  logic                   prev_q;

  // Both lines idle high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // The filtered value only follows after FILTER_CYCLES differing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign clean = filt_q;
`else
  assign clean = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= clean;
  end

  assign level = clean;
  assign rise  = clean & ~prev_q;
  assign fall  = ~clean & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// Oversampling I2C slave with 7-bit address match, write/read bursts and
// repeated START. Define I2C_SLAVE_GLITCH_FILTER_EN to add the input glitch filter.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR    = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES   = 2
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  , parameter int       FILTER_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match,
  output logic [3:0] debug_state
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk(clk), .rst_n(rst_n), .din(scl), .level(scl_level), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk(clk), .rst_n(rst_n), .din(sda), .level(sda_level), .rise(sda_rise), .fall(sda_fall));
`else
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst_n(rst_n), .din(scl), .level(scl_level), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst_n(rst_n), .din(sda), .level(sda_level), .rise(sda_rise), .fall(sda_fall));
`endif

  i2c_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, shift_in, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe, oe_d, rw_q, rw_d;
  logic       rx_valid_d, tx_req_d, busy_d, match_d;
  logic       start_evt, stop_evt, last_bit;

  assign start_evt   = sda_fall & scl_level;
  assign stop_evt    = sda_rise & scl_level;
  assign shift_in    = {shift_q[6:0], sda_level};
  assign last_bit    = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));
  assign sda         = sda_oe ? 1'b0 : 1'bz;
  assign debug_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // In the ACK slots sda_oe doubles as the phase flag: low before the ACK, high during it.
  always_comb begin
    state_d = state_q;
    if (stop_evt) state_d = IDLE;
    else if (start_evt) state_d = ADDR;
    else begin
      case (state_q)
        ADDR:     if (scl_rise && last_bit)
                    state_d = (shift_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && sda_oe) state_d = (rw_q == I2C_READ) ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_rise && last_bit) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && sda_oe) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && last_bit) state_d = RD_ACK;
        RD_ACK:   if (scl_rise && sda_level) state_d = IGNORE;
                  else if (scl_fall) state_d = RD_DATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    oe_d       = sda_oe;
    rw_d       = rw_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy;
    match_d    = addr_match;
    if (stop_evt) begin
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      match_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (start_evt) begin
      oe_d      = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            if (shift_in[7:1] == SLAVE_ADDR) begin
              match_d  = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_in[0];
              tx_req_d = (shift_in[0] == I2C_READ);
            end else begin
              match_d = 1'b0;
            end
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe) oe_d = 1'b1;
          else if (state_q == ADDR_ACK && rw_q == I2C_READ) begin
            shift_d   = tx_data;
            oe_d      = ~tx_data[7];
            bit_cnt_d = '0;
          end else oe_d = 1'b0;
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
          end
        end
        // Rotating keeps every shifter bit live; the wrapped bits are never driven.
        RD_DATA: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = {shift_q[6:0], shift_q[7]};
          oe_d      = last_bit ? 1'b0 : ~shift_q[6];
        end
        RD_ACK: if (scl_rise) begin
          tx_req_d = ~sda_level;
        end else if (scl_fall) begin
          shift_d   = tx_data;
          oe_d      = ~tx_data[7];
          bit_cnt_d = '0;
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_oe     <= 1'b0;
      rw_q       <= I2C_WRITE;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe     <= oe_d;
      rw_q       <= rw_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      tx_req     <= tx_req_d;
      busy       <= busy_d;
      addr_match <= match_d;
    end
  end

endmodule
